// File: rtl/fd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fd_pkg
//  Purpose  : Shared ring geometry and state encoding for the FAST-9 path.
//  Revision : 1.0
// ============================================================================
package fd_pkg;

  localparam int RING_N      = 16;
  localparam int CENTRE_SLOT = 16;

  typedef logic signed [3:0] ring_off_t;

  // Bresenham radius-3 circle, clockwise from the top pixel.
  localparam ring_off_t RING_DX [RING_N] = '{
    4'sd0,  4'sd1,  4'sd2,  4'sd3,  4'sd3,  4'sd3,  4'sd2,  4'sd1,
    4'sd0, -4'sd1, -4'sd2, -4'sd3, -4'sd3, -4'sd3, -4'sd2, -4'sd1
  };
  localparam ring_off_t RING_DY [RING_N] = '{
   -4'sd3, -4'sd3, -4'sd2, -4'sd1,  4'sd0,  4'sd1,  4'sd2,  4'sd3,
    4'sd3,  4'sd3,  4'sd2,  4'sd1,  4'sd0, -4'sd1, -4'sd2, -4'sd3
  };

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fd_state_e;

endpackage
`default_nettype wire

// File: rtl/fd_scan_controller_if.sv
`default_nettype none
// ============================================================================
//  Module   : fd_scan_controller_if
//  Purpose  : Control, fetch handshake and completion signals of the scanner.
//  Revision : 1.0
// ============================================================================
interface fd_scan_controller_if #(
  parameter int ADDR_W = 15
);
  logic              start;
  logic              abort;
  logic              fetch_ready;
  logic              fetch_valid;
  logic [ADDR_W-1:0] ref_addr;
  logic [4:0]        reg_addr;
  logic              readen;
  logic [7:0]        pixel_x;
  logic [7:0]        pixel_y;
  logic              busy;
  logic              frame_done;

  modport master (
    input  start, abort, fetch_ready,
    output fetch_valid, ref_addr, reg_addr, readen, pixel_x, pixel_y, busy, frame_done
  );

  modport slave (
    output start, abort, fetch_ready,
    input  fetch_valid, ref_addr, reg_addr, readen, pixel_x, pixel_y, busy, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/fd_ring_offset.sv
`default_nettype none
// ============================================================================
//  Module   : fd_ring_offset
//  Purpose  : Ring slot index -> signed linear address offset from the centre.
//  Revision : 1.0
// ============================================================================
module fd_ring_offset
  import fd_pkg::*;
#(
  parameter int COLUMNS = 180,
  parameter int OFF_W   = 16
) (
  input  logic [4:0]              i_slot,
  output logic signed [OFF_W-1:0] o_offset
);

  localparam logic signed [OFF_W-1:0] c_COLUMNS = OFF_W'(COLUMNS);

  ring_off_t               w_dx4;
  ring_off_t               w_dy4;
  logic signed [OFF_W-1:0] w_dx;
  logic signed [OFF_W-1:0] w_dy;

  // Slots at or beyond RING_N address the centre itself.
  always_comb begin
    w_dx4 = '0;
    w_dy4 = '0;
    if (i_slot < 5'(RING_N)) begin
      w_dx4 = RING_DX[i_slot[3:0]];
      w_dy4 = RING_DY[i_slot[3:0]];
    end
    w_dx     = {{(OFF_W-4){w_dx4[3]}}, w_dx4};
    w_dy     = {{(OFF_W-4){w_dy4[3]}}, w_dy4};
    o_offset = w_dy * c_COLUMNS + w_dx;
  end

endmodule
`default_nettype wire

// File: rtl/fd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : fd_scan_controller
//  Purpose  : Sweeps frame centres and issues 17 ring/centre fetches per window.
//  Revision : 1.0
// ============================================================================
module fd_scan_controller
  import fd_pkg::*;
#(
  parameter int COLUMNS = 180,
  parameter int ROWS    = 120,
  parameter int BORDER  = 3,
  parameter int ADDR_W  = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  fd_scan_controller_if.master bus
);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_FETCH = FETCH;

  localparam int OFF_W = ADDR_W + 1;

  localparam logic [7:0]        c_FIRST_X      = 8'(BORDER);
  localparam logic [7:0]        c_LAST_X       = 8'(COLUMNS - 1 - BORDER);
  localparam logic [7:0]        c_LAST_Y       = 8'(ROWS - 1 - BORDER);
  localparam logic [ADDR_W-1:0] c_FIRST_CENTRE = ADDR_W'(BORDER * COLUMNS + BORDER);
  localparam logic [ADDR_W-1:0] c_ROW_STEP     = ADDR_W'(2 * BORDER + 1);
  localparam logic [4:0]        c_CENTRE_SLOT  = 5'(CENTRE_SLOT);

  if (BORDER < 3) begin : g_badBorder
    $error("fd_scan_controller: BORDER must cover the ring radius of 3");
  end
  if ((2.0 ** ADDR_W) < (COLUMNS * ROWS)) begin : g_badAddrW
    $error("fd_scan_controller: ADDR_W too narrow for the frame");
  end
  if (COLUMNS > 256 || ROWS > 256) begin : g_badFrame
    $error("fd_scan_controller: pixel coordinates are 8 bits wide");
  end

  logic [0:0]              r_state;
  logic [4:0]              r_slot;
  logic [ADDR_W-1:0]       r_centre;
  logic [7:0]              r_x;
  logic [7:0]              r_y;
  logic                    r_readen;
  logic                    r_frameDone;
  logic [7:0]              r_pixelX;
  logic [7:0]              r_pixelY;

  logic signed [OFF_W-1:0] w_offset;
  logic [OFF_W-1:0]        w_sum;
  logic                    w_fetching;
  logic                    w_lastSlot;
  logic                    w_lastX;
  logic                    w_lastY;

  fd_ring_offset #(
    .COLUMNS (COLUMNS),
    .OFF_W   (OFF_W)
  ) u_ringOffset (
    .i_slot   (r_slot),
    .o_offset (w_offset)
  );

  assign w_fetching = (r_state == ST_FETCH);
  assign w_lastSlot = (r_slot == c_CENTRE_SLOT);
  assign w_lastX    = (r_x == c_LAST_X);
  assign w_lastY    = (r_y == c_LAST_Y);
  assign w_sum      = {1'b0, r_centre} + w_offset;

  // Address and slot read as zero whenever no fetch is being requested.
  assign bus.fetch_valid = w_fetching;
  assign bus.busy        = w_fetching;
  assign bus.ref_addr    = w_fetching ? w_sum[ADDR_W-1:0] : '0;
  assign bus.reg_addr    = w_fetching ? r_slot : '0;
  assign bus.readen      = r_readen;
  assign bus.frame_done  = r_frameDone;
  assign bus.pixel_x     = r_pixelX;
  assign bus.pixel_y     = r_pixelY;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_slot      <= '0;
      r_centre    <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_readen    <= 1'b0;
      r_frameDone <= 1'b0;
      r_pixelX    <= '0;
      r_pixelY    <= '0;
    end else begin
      r_readen    <= 1'b0;
      r_frameDone <= 1'b0;
      if (bus.abort) begin
        r_state  <= ST_IDLE;
        r_slot   <= '0;
        r_centre <= '0;
        r_x      <= '0;
        r_y      <= '0;
        r_pixelX <= '0;
        r_pixelY <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start) begin
              r_state  <= ST_FETCH;
              r_slot   <= '0;
              r_centre <= c_FIRST_CENTRE;
              r_x      <= c_FIRST_X;
              r_y      <= c_FIRST_X;
            end
          end
          ST_FETCH: begin
            if (bus.fetch_ready) begin
              if (w_lastSlot) begin
                // Window complete: the next centre's slot 0 follows with no bubble.
                r_slot   <= '0;
                r_readen <= 1'b1;
                r_pixelX <= r_x;
                r_pixelY <= r_y;
                if (w_lastX) begin
                  if (w_lastY) begin
                    r_frameDone <= 1'b1;
                    r_state     <= ST_IDLE;
                  end else begin
                    r_x      <= c_FIRST_X;
                    r_y      <= r_y + 8'd1;
                    r_centre <= r_centre + c_ROW_STEP;
                  end
                end else begin
                  r_x      <= r_x + 8'd1;
                  r_centre <= r_centre + ADDR_W'(1);
                end
              end else begin
                r_slot <= r_slot + 5'd1;
              end
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fd_scan_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fd_scan_controller
//  Purpose  : Randomised, model-checked bench for two scanner configurations.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_fd_scan_controller;

  localparam int A_COLS = 180, A_ROWS = 120, A_BORDER = 3, A_AW = 15;
  localparam int B_COLS = 64,  B_ROWS = 48,  B_BORDER = 4, B_AW = 12;

  logic clock = 1'b0;
  logic resetA;
  logic resetB;
  always #5 clock = ~clock;

  fd_scan_controller_if #(.ADDR_W(A_AW)) busA ();
  fd_scan_controller_if #(.ADDR_W(B_AW)) busB ();

  fd_scan_controller #(.COLUMNS(A_COLS), .ROWS(A_ROWS), .BORDER(A_BORDER), .ADDR_W(A_AW))
    dutA (.clock(clock), .reset(resetA), .bus(busA.master));
  fd_scan_controller #(.COLUMNS(B_COLS), .ROWS(B_ROWS), .BORDER(B_BORDER), .ADDR_W(B_AW))
    dutB (.clock(clock), .reset(resetB), .bus(busB.master));

  int ringDx [16] = '{0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
  int ringDy [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3, 3, 2, 1, 0, -1, -2, -3};

  int nChecks = 0;
  int nErrors = 0;

  // Reference model state, one entry per DUT (0 = default frame, 1 = small frame).
  bit mOn [2];
  bit mActive [2];
  bit mPend [2];
  bit mPendLast [2];
  int mWin [2];
  int mSlot [2];
  int mPx [2];
  int mPy [2];
  int readenCnt [2];
  int doneCnt [2];
  int lastPx [2];
  int lastPy [2];
  bit stopStall = 1'b0;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: observed %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelStart(input int d);
    mActive[d] = 1'b1;
    mWin[d]    = 0;
    mSlot[d]   = 0;
  endtask

  task automatic modelAbort(input int d);
    mActive[d] = 1'b0;
    mPend[d]   = 1'b0;
    mWin[d]    = 0;
    mSlot[d]   = 0;
  endtask

  task automatic scoreCycle(input int d, input int cols, input int rows, input int border,
                            input logic valid, input logic ready, input logic busy,
                            input logic readen, input logic frameDone,
                            input int refAddr, input int regAddr, input int px, input int py);
    int span, total, wx, wy, expAddr;
    if (!mOn[d]) return;
    span  = cols - 2 * border;
    total = span * (rows - 2 * border);
    if (readen) readenCnt[d]++;
    if (frameDone) begin
      doneCnt[d]++;
      lastPx[d] = px;
      lastPy[d] = py;
    end
    checkValue("readen", readen, mPend[d]);
    checkValue("frame_done", frameDone, mPend[d] & mPendLast[d]);
    if (mPend[d]) begin
      checkValue("pixel_x", px, mPx[d]);
      checkValue("pixel_y", py, mPy[d]);
      mPend[d] = 1'b0;
    end
    checkValue("fetch_valid", valid, mActive[d]);
    checkValue("busy", busy, mActive[d]);
    if (mActive[d]) begin
      wx = border + mWin[d] % span;
      wy = border + mWin[d] / span;
      if (mSlot[d] < 16) expAddr = (wy + ringDy[mSlot[d]]) * cols + wx + ringDx[mSlot[d]];
      else               expAddr = wy * cols + wx;
      checkValue("ref_addr", refAddr, expAddr);
      checkValue("reg_addr", regAddr, mSlot[d]);
      if (ready) begin
        if (mSlot[d] == 16) begin
          mPend[d]     = 1'b1;
          mPx[d]       = wx;
          mPy[d]       = wy;
          mPendLast[d] = (mWin[d] == total - 1);
          mWin[d]++;
          mSlot[d]     = 0;
          if (mPendLast[d]) mActive[d] = 1'b0;
        end else begin
          mSlot[d]++;
        end
      end
    end else begin
      checkValue("idle_ref_addr", refAddr, 0);
      checkValue("idle_reg_addr", regAddr, 0);
    end
  endtask

  always @(negedge clock)
    scoreCycle(0, A_COLS, A_ROWS, A_BORDER, busA.fetch_valid, busA.fetch_ready, busA.busy,
               busA.readen, busA.frame_done, int'(busA.ref_addr), int'(busA.reg_addr),
               int'(busA.pixel_x), int'(busA.pixel_y));

  always @(negedge clock)
    scoreCycle(1, B_COLS, B_ROWS, B_BORDER, busB.fetch_valid, busB.fetch_ready, busB.busy,
               busB.readen, busB.frame_done, int'(busB.ref_addr), int'(busB.reg_addr),
               int'(busB.pixel_x), int'(busB.pixel_y));

  // Random back-pressure on the small-frame DUT: stalls of 1..5 cycles.
  initial begin
    int stallLeft;
    stallLeft = 0;
    busB.fetch_ready = 1'b1;
    while (!stopStall) begin
      @(posedge clock);
      #1;
      if (stallLeft > 0) begin
        busB.fetch_ready = 1'b0;
        stallLeft--;
      end else if ($urandom_range(0, 19) == 0) begin
        busB.fetch_ready = 1'b0;
        stallLeft = int'($urandom_range(1, 5)) - 1;
      end else begin
        busB.fetch_ready = 1'b1;
      end
    end
  end

  task automatic driveCtl(input int d, input logic st, input logic ab);
    if (d == 0) begin
      busA.start = st;
      busA.abort = ab;
    end else begin
      busB.start = st;
      busB.abort = ab;
    end
  endtask

  task automatic startPulse(input int d);
    @(posedge clock); #1; driveCtl(d, 1'b1, 1'b0);
    @(posedge clock); #1; driveCtl(d, 1'b0, 1'b0);
    modelStart(d);
  endtask

  task automatic abortPulse(input int d);
    @(posedge clock); #1; driveCtl(d, 1'b0, 1'b1);
    @(posedge clock); #1; driveCtl(d, 1'b0, 1'b0);
    modelAbort(d);
  endtask

  task automatic checkIdleA(input string tag);
    checkValue({tag, "_valid"}, busA.fetch_valid, 0);
    checkValue({tag, "_busy"}, busA.busy, 0);
    checkValue({tag, "_ref"}, busA.ref_addr, 0);
    checkValue({tag, "_reg"}, busA.reg_addr, 0);
    checkValue({tag, "_px"}, busA.pixel_x, 0);
    checkValue({tag, "_py"}, busA.pixel_y, 0);
  endtask

  initial begin
    bit found;
    resetA = 1'b1;
    resetB = 1'b1;
    driveCtl(0, 1'b0, 1'b0);
    driveCtl(1, 1'b0, 1'b0);
    busA.fetch_ready = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    resetA = 1'b0;
    resetB = 1'b0;
    mOn[0] = 1'b1;
    mOn[1] = 1'b1;
    @(negedge clock);
    checkIdleA("reset");
    checkValue("reset_readen", busA.readen, 0);
    checkValue("reset_frame_done", busA.frame_done, 0);

    // First window of the default frame.
    startPulse(0);
    @(negedge clock);
    checkValue("first_ref", busA.ref_addr, 3);
    checkValue("first_busy", busA.busy, 1);
    repeat (4) @(negedge clock);
    checkValue("slot4_ref", busA.ref_addr, 546);
    repeat (12) @(negedge clock);
    checkValue("centre_ref", busA.ref_addr, 543);
    checkValue("centre_reg", busA.reg_addr, 16);
    @(negedge clock);
    checkValue("first_readen", busA.readen, 1);
    checkValue("first_px", busA.pixel_x, 3);
    checkValue("first_py", busA.pixel_y, 3);
    checkValue("next_ref", busA.ref_addr, 4);
    checkValue("next_reg", busA.reg_addr, 0);

    // Row wrap after centre (176,3).
    found = 1'b0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(negedge clock);
      if (busA.readen && busA.pixel_x == 8'd176) found = 1'b1;
    end
    checkValue("rowwrap_seen", found, 1);
    repeat (16) @(negedge clock);
    checkValue("rowwrap_centre", busA.ref_addr, 723);
    checkValue("rowwrap_reg", busA.reg_addr, 16);
    @(negedge clock);
    checkValue("rowwrap_readen", busA.readen, 1);
    checkValue("rowwrap_px", busA.pixel_x, 3);
    checkValue("rowwrap_py", busA.pixel_y, 4);

    // Start while busy must not disturb the sequence (model keeps going).
    @(posedge clock); #1; driveCtl(0, 1'b1, 1'b0);
    @(posedge clock); #1; driveCtl(0, 1'b0, 1'b0);
    repeat (25) @(negedge clock);

    // Mid-frame abort, then start together with abort.
    abortPulse(0);
    @(negedge clock);
    checkIdleA("abort");
    repeat (20) @(negedge clock);
    @(posedge clock); #1; driveCtl(0, 1'b1, 1'b1);
    @(posedge clock); #1; driveCtl(0, 1'b0, 1'b0);
    @(negedge clock);
    checkValue("start_abort_valid", busA.fetch_valid, 0);

    // Mid-frame asynchronous reset.
    startPulse(0);
    repeat (40) @(negedge clock);
    @(posedge clock); #1;
    resetA = 1'b1;
    modelAbort(0);
    @(negedge clock);
    checkIdleA("reset_mid");
    @(posedge clock); #1;
    resetA = 1'b0;
    repeat (20) @(negedge clock);
    startPulse(0);
    @(negedge clock);
    checkValue("after_reset_ref", busA.ref_addr, 3);
    abortPulse(0);

    // Full small frame under random back-pressure.
    startPulse(1);
    @(negedge clock);
    checkValue("small_first_ref", busB.ref_addr, 68);
    for (int i = 0; i < 90000 && doneCnt[1] == 0; i++) @(negedge clock);
    checkValue("small_frame_seen", doneCnt[1], 1);
    checkValue("small_last_px", lastPx[1], 59);
    checkValue("small_last_py", lastPy[1], 43);
    checkValue("small_busy_end", busB.busy, 0);
    startPulse(1);
    @(negedge clock);
    checkValue("restart_ref", busB.ref_addr, 68);
    checkValue("restart_reg", busB.reg_addr, 0);
    checkValue("small_windows", readenCnt[1], 2240);
    checkValue("small_frame_once", doneCnt[1], 1);
    abortPulse(1);
    repeat (5) @(negedge clock);
    stopStall = 1'b1;

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
`default_nettype wire
